// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - synchronised, debounced push-button with press/release/long-press events
// A raw pin goes through a 2-FF synchroniser, then a five-state debouncer with registered strobes.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4_000_000,
  parameter int unsigned LONG_CYCLES     = 200_000_000,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             key_in,
  output logic             key_state,
  output logic             press_pulse,
  output logic             release_pulse,
  output logic             long_press,
  output logic [CNT_W-1:0] press_count
);

  localparam logic [31:0] DEB_LAST  = 32'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] HOLD_LAST = 32'(LONG_CYCLES - DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    RELEASED    = 3'd0,
    PRESS_CHK   = 3'd1,
    PRESSED     = 3'd2,
    HELD        = 3'd3,
    RELEASE_CHK = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  sync_q;
  logic        k_sync;
  logic [31:0] deb_q, hold_q;
  logic        held_q;
  logic        deb_clr, deb_inc, hold_clr, hold_inc, mark_origin;
  logic        press_d, release_d, long_d;

  // Synchroniser resets to the idle pin level so reset never looks like a press edge.
  always_ff @(posedge sys_clk) begin
    if (rst) sync_q <= {2{KEY_ACTIVE_LOW}};
    else     sync_q <= {sync_q[0], key_in};
  end

  assign k_sync = sync_q[1] ^ KEY_ACTIVE_LOW;

  always_ff @(posedge sys_clk) begin
    if (rst) state_q <= RELEASED;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RELEASED:    if (k_sync) state_d = PRESS_CHK;
      PRESS_CHK: begin
        if (!k_sync)               state_d = RELEASED;
        else if (deb_q == DEB_LAST) state_d = PRESSED;
      end
      PRESSED: begin
        if (!k_sync)                 state_d = RELEASE_CHK;
        else if (hold_q == HOLD_LAST) state_d = HELD;
      end
      HELD:        if (!k_sync) state_d = RELEASE_CHK;
      RELEASE_CHK: begin
        if (k_sync)                 state_d = held_q ? HELD : PRESSED;
        else if (deb_q == DEB_LAST) state_d = RELEASED;
      end
      default:     state_d = RELEASED;
    endcase
  end

  always_comb begin
    deb_clr     = 1'b0;
    deb_inc     = 1'b0;
    hold_clr    = 1'b0;
    hold_inc    = 1'b0;
    mark_origin = 1'b0;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;
    unique case (state_q)
      RELEASED:  deb_clr = k_sync;
      PRESS_CHK: begin
        if (k_sync) begin
          if (deb_q == DEB_LAST) begin
            press_d  = 1'b1;
            hold_clr = 1'b1;
          end else begin
            deb_inc = 1'b1;
          end
        end
      end
      PRESSED: begin
        if (!k_sync) begin
          deb_clr     = 1'b1;
          mark_origin = 1'b1;
        end else if (hold_q == HOLD_LAST) begin
          long_d = 1'b1;
        end else begin
          hold_inc = 1'b1;
        end
      end
      HELD: begin
        if (!k_sync) begin
          deb_clr     = 1'b1;
          mark_origin = 1'b1;
        end
      end
      RELEASE_CHK: begin
        if (!k_sync) begin
          if (deb_q == DEB_LAST) release_d = 1'b1;
          else                   deb_inc   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // held_q remembers whether a release check started from HELD, so a glitch cannot re-arm long_press.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      deb_q         <= '0;
      hold_q        <= '0;
      held_q        <= 1'b0;
      key_state     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      press_count   <= '0;
    end else begin
      if (deb_clr)      deb_q <= '0;
      else if (deb_inc) deb_q <= deb_q + 32'd1;
      if (hold_clr)      hold_q <= '0;
      else if (hold_inc) hold_q <= hold_q + 32'd1;
      if (mark_origin) held_q <= (state_q == HELD);
      press_pulse   <= press_d;
      release_pulse <= release_d;
      long_press    <= long_d;
      if (press_d) begin
        key_state <= 1'b1;
        if (press_count != '1) press_count <= press_count + CNT_W'(1);
      end else if (release_d) begin
        key_state <= 1'b0;
      end
    end
  end

endmodule
